// File: rtl/reg_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_op_sequencer
// Description : Splits each two-operand instruction into source-read,
//               destination-read and write-back cycles for a single-port
//               register file, and keeps the ZF/SF/CF flags.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_op_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [1:0]       instr_dst,
    input  logic [1:0]       instr_src,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [1:0]       rf_sel,
    output logic             rf_we,
    output logic [WIDTH-1:0] rf_wdata,
    input  logic [WIDTH-1:0] rf_rdata,
    output logic             done,
    output logic             flag_z,
    output logic             flag_s,
    output logic             flag_c
);

    localparam logic [2:0] c_OP_MOV_RR = 3'd0;
    localparam logic [2:0] c_OP_MOV_RI = 3'd1;
    localparam logic [2:0] c_OP_ADD    = 3'd2;
    localparam logic [2:0] c_OP_SUB    = 3'd3;
    localparam logic [2:0] c_OP_AND    = 3'd4;
    localparam logic [2:0] c_OP_OR     = 3'd5;
    localparam logic [2:0] c_OP_XOR    = 3'd6;
    localparam logic [2:0] c_OP_CMP    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_SRC = 2'd1,
        ST_RD_DST = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    state_t           r_state_q,  w_state_d;
    logic [2:0]       r_op_q,     w_op_d;
    logic [1:0]       r_dst_q,    w_dst_d;
    logic [1:0]       r_src_q,    w_src_d;
    logic [WIDTH-1:0] r_imm_q,    w_imm_d;
    logic [WIDTH-1:0] r_tmp_q,    w_tmp_d;
    logic [WIDTH-1:0] r_result_q, w_result_d;
    logic             r_carry_q,  w_carry_d;
    logic             r_z_q,      w_z_d;
    logic             r_s_q,      w_s_d;
    logic             r_c_q,      w_c_d;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_is_alu;

    // A is the destination value on the bus in RD_DST, B the latched source.
    always_comb begin
        w_sum     = {1'b0, rf_rdata} + {1'b0, r_tmp_q};
        w_diff    = {1'b0, rf_rdata} - {1'b0, r_tmp_q};
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (r_op_q)
            c_OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
            end
            c_OP_SUB, c_OP_CMP: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_c   = w_diff[WIDTH];
            end
            c_OP_AND: w_alu_res = rf_rdata & r_tmp_q;
            c_OP_OR:  w_alu_res = rf_rdata | r_tmp_q;
            c_OP_XOR: w_alu_res = rf_rdata ^ r_tmp_q;
            default:  w_alu_res = '0;
        endcase
    end

    assign w_is_alu = (r_op_q != c_OP_MOV_RR) && (r_op_q != c_OP_MOV_RI);

    always_comb begin
        w_state_d  = r_state_q;
        w_op_d     = r_op_q;
        w_dst_d    = r_dst_q;
        w_src_d    = r_src_q;
        w_imm_d    = r_imm_q;
        w_tmp_d    = r_tmp_q;
        w_result_d = r_result_q;
        w_carry_d  = r_carry_q;
        w_z_d      = r_z_q;
        w_s_d      = r_s_q;
        w_c_d      = r_c_q;
        case (r_state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    w_op_d    = instr_op;
                    w_dst_d   = instr_dst;
                    w_src_d   = instr_src;
                    w_imm_d   = instr_imm;
                    w_state_d = (instr_op == c_OP_MOV_RI) ? ST_WRITE : ST_RD_SRC;
                end
            end
            ST_RD_SRC: begin
                w_tmp_d   = rf_rdata;
                w_state_d = (r_op_q == c_OP_MOV_RR) ? ST_WRITE : ST_RD_DST;
            end
            ST_RD_DST: begin
                w_result_d = w_alu_res;
                w_carry_d  = w_alu_c;
                w_state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                if (w_is_alu) begin
                    w_z_d = (r_result_q == '0);
                    w_s_d = r_result_q[WIDTH-1];
                    w_c_d = r_carry_q;
                end
                w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Outputs decode registered state only; reset also masks the write strobe
    // so an abort during WRITE cannot corrupt the register file.
    always_comb begin
        instr_ready = (r_state_q == ST_IDLE);
        rf_sel      = 2'd0;
        rf_we       = 1'b0;
        rf_wdata    = '0;
        done        = 1'b0;
        case (r_state_q)
            ST_RD_SRC: rf_sel = r_src_q;
            ST_RD_DST: rf_sel = r_dst_q;
            ST_WRITE: begin
                rf_sel = r_dst_q;
                done   = 1'b1;
                rf_we  = (r_op_q != c_OP_CMP) && !reset;
                if (r_op_q == c_OP_MOV_RI) begin
                    rf_wdata = r_imm_q;
                end else if (r_op_q == c_OP_MOV_RR) begin
                    rf_wdata = r_tmp_q;
                end else begin
                    rf_wdata = r_result_q;
                end
            end
            default: rf_sel = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_op_q     <= '0;
            r_dst_q    <= '0;
            r_src_q    <= '0;
            r_imm_q    <= '0;
            r_tmp_q    <= '0;
            r_result_q <= '0;
            r_carry_q  <= 1'b0;
            r_z_q      <= 1'b0;
            r_s_q      <= 1'b0;
            r_c_q      <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_op_q     <= w_op_d;
            r_dst_q    <= w_dst_d;
            r_src_q    <= w_src_d;
            r_imm_q    <= w_imm_d;
            r_tmp_q    <= w_tmp_d;
            r_result_q <= w_result_d;
            r_carry_q  <= w_carry_d;
            r_z_q      <= w_z_d;
            r_s_q      <= w_s_d;
            r_c_q      <= w_c_d;
        end
    end

    assign flag_z = r_z_q;
    assign flag_s = r_s_q;
    assign flag_c = r_c_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_op_sequencer
// Description : Directed and random instructions against a behavioural
//               register-file/flag model of reg_op_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [1:0]  instr_dst;
    logic [1:0]  instr_src;
    logic [15:0] instr_imm;
    logic [1:0]  rf_sel;
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic [15:0] rf_rdata;
    logic        done;
    logic        flag_z;
    logic        flag_s;
    logic        flag_c;

    logic [15:0] rf_mem [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    logic [15:0] m_rf   [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    logic        m_z, m_s, m_c;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rf_rdata = rf_mem[rf_sel];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_sel] <= rf_wdata;
    end

    reg_op_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_dst(instr_dst), .instr_src(instr_src),
        .instr_imm(instr_imm),
        .rf_sel(rf_sel), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .done(done), .flag_z(flag_z), .flag_s(flag_s), .flag_c(flag_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) check({tag, "_reg"}, rf_mem[i], m_rf[i]);
        check({tag, "_z"}, flag_z, m_z);
        check({tag, "_s"}, flag_s, m_s);
        check({tag, "_c"}, flag_c, m_c);
        check({tag, "_ready"}, instr_ready, 1'b1);
    endtask

    // Architectural effect of one instruction on the model; returns value to write.
    task automatic model_exec(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src,
                              input logic [15:0] imm, output logic [15:0] wval);
        int a, b, t;
        logic [15:0] r;
        logic c;
        a = m_rf[dst];
        b = m_rf[src];
        c = 1'b0;
        case (op)
            3'd0: r = m_rf[src];
            3'd1: r = imm;
            3'd2: begin t = a + b; r = t[15:0]; c = (t > 65535); end
            3'd3, 3'd7: begin t = a - b; r = t[15:0]; c = (a < b); end
            3'd4: r = m_rf[dst] & m_rf[src];
            3'd5: r = m_rf[dst] | m_rf[src];
            default: r = m_rf[dst] ^ m_rf[src];
        endcase
        wval = r;
        if (op != 3'd7) m_rf[dst] = r;
        if (op >= 3'd2) begin
            m_z = (r == 16'h0);
            m_s = r[15];
            m_c = c;
        end
    endtask

    task automatic run_instr(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src,
                             input logic [15:0] imm);
        int lat;
        logic [1:0] sel_seq [3];
        logic [15:0] wval;
        lat = (op == 3'd1) ? 1 : (op == 3'd0) ? 2 : 3;
        sel_seq[0] = (op == 3'd1) ? dst : src;
        sel_seq[1] = dst;
        sel_seq[2] = dst;
        model_exec(op, dst, src, imm, wval);
        @(negedge clk);
        check("pre_ready", instr_ready, 1'b1);
        instr_valid = 1'b1;
        instr_op = op; instr_dst = dst; instr_src = src; instr_imm = imm;
        @(posedge clk);
        #1;
        // Junk presented while busy must be ignored.
        instr_valid = 1'($urandom_range(0, 1));
        instr_op = 3'($urandom); instr_dst = 2'($urandom);
        instr_src = 2'($urandom); instr_imm = 16'($urandom);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check("sel", rf_sel, sel_seq[k]);
            check("busy_ready", instr_ready, 1'b0);
            check("done", done, (k == lat - 1));
            check("we", rf_we, (k == lat - 1) && (op != 3'd7));
            if (k == lat - 1 && op != 3'd7) check("wdata", rf_wdata, wval);
            if (k == lat - 1) instr_valid = 1'b0;
        end
        @(negedge clk);
        check_state("post");
        check("idle_done", done, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] wval;
        m_z = 1'b0; m_s = 1'b0; m_c = 1'b0;
        reset = 1'b1;
        instr_valid = 1'b0; instr_op = '0; instr_dst = '0; instr_src = '0; instr_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", instr_ready, 1'b1);
        check("rst_sel", rf_sel, 2'd0);
        check("rst_we", rf_we, 1'b0);
        check("rst_wdata", rf_wdata, 16'h0);
        check("rst_done", done, 1'b0);
        check("rst_flags", {flag_z, flag_s, flag_c}, 3'b000);
        reset = 1'b0;

        run_instr(3'd1, 2'd0, 2'd0, 16'h1234);            // MOV_RI AX
        run_instr(3'd1, 2'd0, 2'd0, 16'hFFFF);
        run_instr(3'd1, 2'd1, 2'd0, 16'h0001);
        run_instr(3'd2, 2'd0, 2'd1, 16'h0000);            // ADD AX,BX -> 0, Z C
        run_instr(3'd1, 2'd0, 2'd0, 16'h0003);
        run_instr(3'd1, 2'd2, 2'd0, 16'h0005);
        run_instr(3'd7, 2'd0, 2'd2, 16'h0000);            // CMP AX,CX
        run_instr(3'd1, 2'd1, 2'd0, 16'hA5A5);

        // MOV_RR DX,BX with a second instruction held on the bus.
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'd0; instr_dst = 2'd3; instr_src = 2'd1;
        @(posedge clk);
        #1;
        instr_op = 3'd1; instr_dst = 2'd2; instr_imm = 16'h5555;
        @(negedge clk);
        check("b2b_rdsrc_ready", instr_ready, 1'b0);
        check("b2b_rdsrc_sel", rf_sel, 2'd1);
        @(negedge clk);
        check("b2b_wr_ready", instr_ready, 1'b0);
        check("b2b_wr_done", done, 1'b1);
        check("b2b_wr_data", rf_wdata, 16'hA5A5);
        check("b2b_wr_sel", rf_sel, 2'd3);
        @(negedge clk);
        check("b2b_idle_ready", instr_ready, 1'b1);
        check("b2b_dx", rf_mem[3], 16'hA5A5);
        model_exec(3'd0, 2'd3, 2'd1, 16'h0, wval);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        check("b2b_2nd_done", done, 1'b1);
        check("b2b_2nd_sel", rf_sel, 2'd2);
        check("b2b_2nd_data", rf_wdata, 16'h5555);
        model_exec(3'd1, 2'd2, 2'd0, 16'h5555, wval);
        @(negedge clk);
        check_state("b2b_post");

        // Reset during RD_DST of XOR AX,BX aborts without writing.
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'd6; instr_dst = 2'd0; instr_src = 2'd1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_rddst_sel", rf_sel, 2'd0);
        reset = 1'b1;
        check("abort_we", rf_we, 1'b0);
        @(negedge clk);
        check("abort_we_after", rf_we, 1'b0);
        check("abort_done", done, 1'b0);
        reset = 1'b0;
        m_z = 1'b0; m_s = 1'b0; m_c = 1'b0;
        check_state("abort");

        run_instr(3'd1, 2'd1, 2'd0, 16'h7777);
        run_instr(3'd3, 2'd1, 2'd1, 16'h0000);            // SUB BX,BX
        run_instr(3'd1, 2'd0, 2'd0, 16'hFFFF);
        run_instr(3'd1, 2'd3, 2'd0, 16'h8001);
        run_instr(3'd2, 2'd0, 2'd3, 16'h0000);            // ADD sets C
        run_instr(3'd6, 2'd3, 2'd3, 16'h0000);            // XOR DX,DX clears C
        run_instr(3'd0, 2'd0, 2'd0, 16'h0000);            // MOV_RR AX,AX

        for (int n = 0; n < 60; n++) begin
            run_instr(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
- Multi-cycle execute/write-back sequencer placed directly upstream of the 4-entry, 16-bit register file (AX, BX, CX, DX).
- The register file has one shared select for read and write, with a combinational read and a write on the clock edge. This block therefore serialises each two-operand instruction into separate source-read, destination-read and write-back cycles.
- It accepts one decoded instruction at a time over a valid/ready handshake, drives the register-file select, write-enable and write-data lines, and holds ZF, SF and CF.

Parameters:
WIDTH, 16, datapath width; must match the register file. Only 16 is verified.

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high; sampled on the rising edge of clk
instr_valid  in  1  decoded instruction present
instr_ready  out  1  high only in IDLE; handshake completes when instr_valid & instr_ready on a clock edge
instr_op  in  3  0 MOV_RR, 1 MOV_RI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 CMP
instr_dst  in  2  destination register index (0 AX, 1 BX, 2 CX, 3 DX)
instr_src  in  2  source register index (ignored for MOV_RI)
instr_imm  in  WIDTH  immediate (used only by MOV_RI)
rf_sel  out  2  register-file select (shared read/write)
rf_we  out  1  register-file write enable
rf_wdata  out  WIDTH  register-file write data
rf_rdata  in  WIDTH  combinational read data of the register addressed by rf_sel
done  out  1  one-cycle pulse in the WRITE cycle
flag_z  out  1  zero flag
flag_s  out  1  sign flag (result MSB)
flag_c  out  1  carry (ADD) / borrow (SUB, CMP)

Behaviour:
- Reset: state=IDLE; instr_ready=1; rf_sel=0; rf_we=0; rf_wdata=0; done=0; all flags=0; internal op/dst/src/imm/tmp/result registers=0.
- Reset mid-operation aborts immediately. No rf_we pulse occurs in or after the reset cycle, and the next state is IDLE.
- States: IDLE, RD_SRC, RD_DST, WRITE.
- IDLE:
  - instr_ready=1, rf_we=0, rf_sel=0.
  - On handshake, latch op/dst/src/imm.
  - Next state: MOV_RI -> WRITE; all other ops -> RD_SRC.
  - instr_valid while not in IDLE is ignored; the instruction is not latched.
- RD_SRC:
  - rf_sel=src; tmp <= rf_rdata at end of cycle.
  - Next state: MOV_RR -> WRITE; else -> RD_DST.
- RD_DST:
  - rf_sel=dst.
  - result <= ALU(op, rf_rdata as A, tmp as B); carry/borrow is captured in the same edge.
  - Next state: WRITE.
- WRITE:
  - rf_sel=dst; done=1; rf_wdata=result (MOV_RI: imm; MOV_RR: tmp).
  - rf_we=1 for all ops except CMP, where rf_we=0.
  - Next state: IDLE.
- Outputs are registered-state decodes: rf_sel, rf_we, rf_wdata and done depend only on state and internal registers, never on instr_* inputs.
- ALU (WIDTH-bit, wrap-around modulo 2^WIDTH):
  - ADD: A+B; C = carry out of the MSB.
  - SUB, CMP: A-B; C = 1 when A<B unsigned.
  - AND, OR, XOR: bitwise; C=0.
- Flags update at the end of the WRITE cycle, for ALU ops only:
  - Z = (result==0).
  - S = result[WIDTH-1].
  - MOV_RR and MOV_RI leave all flags unchanged.
- src==dst is legal:
  - SUB AX,AX gives 0 with Z=1.
  - MOV_RR AX,AX rewrites the same value.
- Latency from handshake edge to done cycle:
  - MOV_RI: done is high in the 1st cycle after the handshake.
  - MOV_RR: 2nd cycle.
  - ALU ops: 3rd cycle.
- Throughput: the next instruction can be accepted one cycle after WRITE. Per-instruction occupancy is therefore 2, 3 or 4 cycles.
- Register-file write takes effect at the edge ending WRITE, so a following instruction reads the new value.

Test Plan:
- Reset, then MOV_RI dst=AX imm=0x1234 -> 1 cycle after handshake: rf_sel=0, rf_we=1, rf_wdata=0x1234, done=1; AX reads back 0x1234; flags remain 0.
- AX=0xFFFF, BX=0x0001, ADD dst=AX src=BX -> rf_sel sequence 1,0,0; write of 0x0000 in the 3rd cycle; Z=1, C=1, S=0.
- AX=0x0003, CX=0x0005, CMP dst=AX src=CX -> rf_we stays 0 throughout; done pulses; Z=0, S=1, C=1; AX still 0x0003.
- MOV_RR dst=DX src=BX (BX=0xA5A5) while holding instr_valid high with a second op -> DX=0xA5A5 after 2 cycles; second op accepted only once back in IDLE; instr_ready low during RD_SRC/WRITE.
- Assert reset during RD_DST of XOR AX,BX -> no rf_we pulse; state IDLE next cycle; flags 0; AX unchanged.
- SUB BX,BX (BX=0x7777) -> BX=0x0000, Z=1, C=0, S=0; then XOR with equal values confirms C=0.
